tri_centroid: RTL and testbench
===============================

Name: tri_centroid

Overview:
- Sequential stage directly downstream of the vertex solvers.
- Each solver produces one triangle vertex (xT, yT) per evaluation. This block collects three vertices per localisation frame over a valid/ready handshake and sums them.
- It then divides the sums by 3 with a multi-cycle restoring divider and presents the centroid (estimated target position) on a valid/ready output.
- Shared sequential divider is used instead of a combinational constant divider to keep area low.

Parameters:
N, 8, anchor coordinate width; vertex coordinates are N+2 bits signed, matching the vertex solver output.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
clear  input  1  synchronous frame abort; discards partial accumulation and any in-flight division
vtx_valid  input  1  vertex on xT/yT is valid
vtx_ready  output  1  block can accept a vertex
xT  input  N+2  signed vertex x
yT  input  N+2  signed vertex y
out_valid  output  1  centroid on xC/yC is valid
out_ready  input  1  consumer accepts centroid
xC  output  N+2  signed centroid x
yC  output  N+2  signed centroid y
busy  output  1  high in DIV state

Behaviour:
- Reset (async, rst=1): state=COLLECT, vertex count=0, accumulators=0, xC=yC=0, out_valid=0, busy=0, vtx_ready=0 while rst high.
- States: COLLECT, DIV, DONE.
- COLLECT:
  - vtx_ready=1.
  - Handshake = vtx_valid & vtx_ready.
  - Each handshake adds sign-extended xT/yT into N+4-bit signed accumulators accX/accY and increments the count.
  - On the 3rd handshake: count returns to 0 and the state moves to DIV.
  - In DIV, the divider is loaded with |accX|, |accY| (N+3-bit unsigned magnitudes, including the just-accepted vertex) and the sign bits.
- DIV:
  - vtx_ready=0, busy=1.
  - One restoring step per cycle, shift remainder, compare with 3, subtract, shift in quotient bit. X and Y run in parallel.
  - Exactly N+3 cycles, then the state moves to DONE.
  - On entering DONE: xC/yC = quotient, negated if the sum was negative. This gives truncation toward zero.
- DONE:
  - out_valid=1; xC/yC held stable.
  - On out_valid & out_ready: out_valid=0, accumulators cleared, state moves to COLLECT.
  - out_valid must not drop without a handshake.
  - xC/yC keep their last value after the handshake until the next result.
- Latency: if the 3rd vertex is accepted at edge k, out_valid rises after edge k+N+4 (12 for N=8). Throughput is at most one centroid per N+8 cycles.
- Width rules:
  - Sum range is [-3·2^(N+1), 3·(2^(N+1)-1)], which fits N+4 signed.
  - Quotient range is [-2^(N+1), 2^(N+1)-1], which fits N+2 signed with no saturation required.
- clear (synchronous, highest priority after rst):
  - In any state: count=0, accumulators=0, out_valid=0, state moves to COLLECT.
  - A vertex presented in the same cycle as clear is dropped, although vtx_ready is high in COLLECT.
  - xC/yC are not modified.
- Reset mid-frame or mid-DIV: immediate return to the reset values; the partial frame is lost.
- vtx_valid is ignored outside COLLECT, because vtx_ready=0 there.

Test Plan:
- Basic frame (N=8): vertices (10,20), (13,-4), (-2,7) back-to-back -> sums (21,23); out_valid 12 cycles after 3rd accept; xC=7, yC=7.
- Negative truncation: vertices (-10,-1), (-10,-1), (-11,-1) -> sums (-31,-3) -> xC=-10, yC=-1. This checks rounding toward zero, not floor.
- Extremes (N=8, 10-bit vertices): three (-512,511) -> xC=-512, yC=511. Then three (511,-512) -> (511,-512). No overflow.
- Backpressure:
  - Hold out_ready=0 for 20 cycles after out_valid -> out_valid stays 1, xC/yC stable, vtx_ready stays 0.
  - Then out_ready=1 for one cycle -> out_valid=0 and vtx_ready=1 on the next cycle.
- Abort and gaps:
  - Accept 2 vertices, then assert clear together with vtx_valid -> vertex dropped, count=0.
  - Next frame (3,3), (3,3), (3,3), sent with vtx_valid gaps between vertices -> (3,3).
- Async reset during DIV: assert rst mid-division asynchronously (not on a clock edge) -> all outputs return to 0 immediately, with no out_valid pulse. After release, a fresh frame is computed correctly.

Source files
------------

// File: rtl/tri_centroid.sv
// Collects three solver vertices per frame, sums them and divides by 3
// with a shared restoring divider, presenting the centroid on valid/ready.
module tri_centroid #(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                vtx_valid,
  output logic                vtx_ready,
  input  logic signed [N+1:0] xT,
  input  logic signed [N+1:0] yT,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N+1:0] xC,
  output logic signed [N+1:0] yC,
  output logic                busy
);

  localparam int VW = N + 2;
  localparam int AW = N + 4;
  localparam int MW = N + 3;
  localparam int SW = $clog2(N + 4);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_DIV     = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  localparam logic [SW-1:0] LAST = SW'(N + 3);

  logic [1:0]          r_state;
  logic [1:0]          r_cnt;
  logic signed [AW-1:0] r_accx;
  logic signed [AW-1:0] r_accy;
  logic [MW-1:0]       r_qx;
  logic [MW-1:0]       r_qy;
  logic [1:0]          r_rx;
  logic [1:0]          r_ry;
  logic                r_sx;
  logic                r_sy;
  logic [SW-1:0]       r_step;
  logic [VW-1:0]       r_xc;
  logic [VW-1:0]       r_yc;
  logic                r_ov;

  logic                w_hs;
  logic signed [AW-1:0] w_sumx;
  logic signed [AW-1:0] w_sumy;
  logic [MW+1:0]       w_stx;
  logic [MW+1:0]       w_sty;

  function automatic logic [MW-1:0] f_mag(
    input logic signed [AW-1:0] a
  );
    return MW'(a[AW-1] ? -a : a);
  endfunction

  // One restoring step: remainder stays below 3, so 2 bits suffice.
  function automatic logic [MW+1:0] f_step(
    input logic [1:0]    r,
    input logic [MW-1:0] q
  );
    logic [2:0] t;
    logic       ge;
    t  = {r, q[MW-1]};
    ge = (t >= 3'd3);
    return {ge ? 2'(t - 3'd3) : t[1:0],
            q[MW-2:0], ge};
  endfunction

  function automatic logic [VW-1:0] f_res(
    input logic          s,
    input logic [MW-1:0] q
  );
    return VW'(s ? -q : q);
  endfunction

  assign vtx_ready = (r_state == S_COLLECT) & ~rst;
  assign busy      = (r_state == S_DIV);
  assign out_valid = r_ov;
  assign xC        = r_xc;
  assign yC        = r_yc;

  assign w_hs   = vtx_valid & vtx_ready;
  assign w_sumx = r_accx + {{2{xT[N+1]}}, xT};
  assign w_sumy = r_accy + {{2{yT[N+1]}}, yT};
  assign w_stx  = f_step(r_rx, r_qx);
  assign w_sty  = f_step(r_ry, r_qy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_COLLECT;
      r_cnt   <= '0;
      r_accx  <= '0;
      r_accy  <= '0;
      r_qx    <= '0;
      r_qy    <= '0;
      r_rx    <= '0;
      r_ry    <= '0;
      r_sx    <= 1'b0;
      r_sy    <= 1'b0;
      r_step  <= '0;
      r_xc    <= '0;
      r_yc    <= '0;
      r_ov    <= 1'b0;
    end else if (clear) begin
      r_state <= S_COLLECT;
      r_cnt   <= '0;
      r_accx  <= '0;
      r_accy  <= '0;
      r_step  <= '0;
      r_ov    <= 1'b0;
    end else begin
      case (r_state)
        S_COLLECT: begin
          if (w_hs) begin
            r_accx <= w_sumx;
            r_accy <= w_sumy;
            if (r_cnt == 2'd2) begin
              r_cnt   <= '0;
              r_step  <= '0;
              r_state <= S_DIV;
            end else begin
              r_cnt <= r_cnt + 2'd1;
            end
          end
        end
        S_DIV: begin
          // Step 0 loads magnitudes; steps 1..N+3 each retire a bit.
          if (r_step == '0) begin
            r_qx   <= f_mag(r_accx);
            r_qy   <= f_mag(r_accy);
            r_rx   <= '0;
            r_ry   <= '0;
            r_sx   <= r_accx[AW-1];
            r_sy   <= r_accy[AW-1];
            r_step <= SW'(1);
          end else begin
            {r_rx, r_qx} <= w_stx;
            {r_ry, r_qy} <= w_sty;
            if (r_step == LAST) begin
              r_xc    <= f_res(r_sx, w_stx[MW-1:0]);
              r_yc    <= f_res(r_sy, w_sty[MW-1:0]);
              r_ov    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_step <= r_step + SW'(1);
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_ov    <= 1'b0;
            r_accx  <= '0;
            r_accy  <= '0;
            r_state <= S_COLLECT;
          end
        end
        default: r_state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_centroid.sv
// Directed bench for tri_centroid: frames, truncation, extremes,
// backpressure, abort and asynchronous reset.
module tb_tri_centroid;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              vtx_valid;
  logic              vtx_ready;
  logic signed [9:0] xT;
  logic signed [9:0] yT;
  logic              out_valid;
  logic              out_ready;
  logic signed [9:0] xC;
  logic signed [9:0] yC;
  logic              busy;

  int checks = 0;
  int errors = 0;

  tri_centroid #(.N(8)) dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .vtx_valid(vtx_valid),
    .vtx_ready(vtx_ready),
    .xT(xT),
    .yT(yT),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .xC(xC),
    .yC(yC),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic send_vtx(input int x, input int y);
    vtx_valid = 1'b1;
    xT = 10'(x);
    yT = 10'(y);
    @(posedge clk);
    #1;
    vtx_valid = 1'b0;
  endtask

  task automatic wait_ov(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear = 1'b0;
    vtx_valid = 1'b0;
    out_ready = 1'b0;
    xT = '0;
    yT = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({vtx_ready, out_valid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b want 000",
               {vtx_ready, out_valid, busy});
    end
    checks++;
    if (xC !== 10'sd0 || yC !== 10'sd0) begin
      errors++;
      $display("FAIL reset_out got %0d,%0d want 0,0",
               xC, yC);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (vtx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", vtx_ready);
    end
  endtask

  task automatic test_basic();
    int cyc;
    send_vtx(10, 20);
    send_vtx(13, -4);
    send_vtx(-2, 7);
    checks++;
    if (busy !== 1'b1 || vtx_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy got %b%b want 10",
               busy, vtx_ready);
    end
    wait_ov(cyc);
    checks++;
    if (cyc != 12) begin
      errors++;
      $display("FAIL basic_latency got %0d want 12", cyc);
    end
    checks++;
    if (int'(xC) != 7 || int'(yC) != 7) begin
      errors++;
      $display("FAIL basic_val got %0d,%0d want 7,7", xC, yC);
    end
    take();
    checks++;
    if (out_valid !== 1'b0 || vtx_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_hs got ov=%b rdy=%b want 0 1",
               out_valid, vtx_ready);
    end
  endtask

  task automatic test_neg_trunc();
    int cyc;
    send_vtx(-10, -1);
    send_vtx(-10, -1);
    send_vtx(-11, -1);
    wait_ov(cyc);
    checks++;
    if (int'(xC) != -10 || int'(yC) != -1) begin
      errors++;
      $display("FAIL neg_trunc got %0d,%0d want -10,-1",
               xC, yC);
    end
    take();
  endtask

  task automatic test_extremes();
    int cyc;
    repeat (3) send_vtx(-512, 511);
    wait_ov(cyc);
    checks++;
    if (int'(xC) != -512 || int'(yC) != 511) begin
      errors++;
      $display("FAIL extreme_a got %0d,%0d want -512,511",
               xC, yC);
    end
    take();
    repeat (3) send_vtx(511, -512);
    wait_ov(cyc);
    checks++;
    if (int'(xC) != 511 || int'(yC) != -512) begin
      errors++;
      $display("FAIL extreme_b got %0d,%0d want 511,-512",
               xC, yC);
    end
    take();
  endtask

  task automatic test_backpressure();
    int cyc;
    send_vtx(1, 2);
    send_vtx(3, 4);
    send_vtx(5, 6);
    wait_ov(cyc);
    vtx_valid = 1'b1;
    xT = 10'sd100;
    yT = 10'sd100;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || vtx_ready !== 1'b0 ||
          int'(xC) != 3 || int'(yC) != 4) begin
        errors++;
        $display("FAIL bp_hold c%0d got ov=%b rdy=%b %0d,%0d want 1 0 3,4",
                 i, out_valid, vtx_ready, xC, yC);
      end
    end
    vtx_valid = 1'b0;
    take();
    checks++;
    if (out_valid !== 1'b0 || vtx_ready !== 1'b1 ||
        int'(xC) != 3 || int'(yC) != 4) begin
      errors++;
      $display("FAIL bp_release got ov=%b rdy=%b %0d,%0d want 0 1 3,4",
               out_valid, vtx_ready, xC, yC);
    end
  endtask

  task automatic test_abort_gaps();
    int cyc;
    send_vtx(100, 100);
    send_vtx(100, 100);
    clear = 1'b1;
    send_vtx(50, 50);
    clear = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || vtx_ready !== 1'b1 ||
        busy !== 1'b0 || int'(xC) != 3) begin
      errors++;
      $display("FAIL abort_state got ov=%b rdy=%b busy=%b x=%0d want 0 1 0 3",
               out_valid, vtx_ready, busy, xC);
    end
    for (int i = 0; i < 3; i++) begin
      send_vtx(3, 3);
      if (i < 2) begin
        xT = 10'sd77;
        yT = -10'sd77;
        repeat (2) @(posedge clk);
        #1;
      end
    end
    wait_ov(cyc);
    checks++;
    if (cyc != 12) begin
      errors++;
      $display("FAIL gaps_latency got %0d want 12", cyc);
    end
    checks++;
    if (int'(xC) != 3 || int'(yC) != 3) begin
      errors++;
      $display("FAIL gaps_val got %0d,%0d want 3,3", xC, yC);
    end
    take();
  endtask

  task automatic test_clear_div();
    int seen;
    send_vtx(60, 60);
    send_vtx(60, 60);
    send_vtx(60, 60);
    repeat (4) @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    checks++;
    if (busy !== 1'b0 || vtx_ready !== 1'b1) begin
      errors++;
      $display("FAIL clrdiv_state got busy=%b rdy=%b want 0 1",
               busy, vtx_ready);
    end
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0 || int'(xC) != 3) begin
      errors++;
      $display("FAIL clrdiv_out got pulses=%0d x=%0d want 0 3",
               seen, xC);
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    int seen;
    send_vtx(9, 9);
    send_vtx(9, 9);
    send_vtx(9, 9);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({vtx_ready, out_valid, busy} !== 3'b000 ||
        xC !== 10'sd0 || yC !== 10'sd0) begin
      errors++;
      $display("FAIL arst_now got %b %0d,%0d want 000 0,0",
               {vtx_ready, out_valid, busy}, xC, yC);
    end
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL arst_pulse got %0d want 0", seen);
    end
    send_vtx(6, -6);
    send_vtx(6, -6);
    send_vtx(7, -7);
    wait_ov(cyc);
    checks++;
    if (cyc != 12 || int'(xC) != 6 || int'(yC) != -6) begin
      errors++;
      $display("FAIL arst_frame got lat=%0d %0d,%0d want 12 6,-6",
               cyc, xC, yC);
    end
    take();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_neg_trunc();
    test_extremes();
    test_backpressure();
    test_abort_gaps();
    test_clear_div();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
